// File: rtl/otter_iobus_timer.sv
// rtl/otter_iobus_timer.sv - memory-mapped interval timer on the OTTER I/O bus
module otter_iobus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1101_0000,
    parameter int          PRESCALE  = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        INTR
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [2:0]  ctrl_q,  ctrl_d;
    logic [31:0] load_q,  load_d;
    logic [31:0] count_q, count_d;
    logic        exp_q,   exp_d;
    logic [15:0] presc_q, presc_d;
    logic        intr_q,  intr_d;

    logic sel_ctrl, sel_load, sel_count, sel_stat;
    logic tick;

    assign sel_ctrl  = (IOBUS_ADDR == BASE_ADDR);
    assign sel_load  = (IOBUS_ADDR == BASE_ADDR + 32'h4);
    assign sel_count = (IOBUS_ADDR == BASE_ADDR + 32'h8);
    assign sel_stat  = (IOBUS_ADDR == BASE_ADDR + 32'hC);

    assign tick = ctrl_q[0] && (presc_q == PRE_MAX);

    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        presc_d = (!ctrl_q[0] || tick) ? 16'd0 : presc_q + 16'd1;
        intr_d  = 1'b0;

        // Clear is evaluated before the tick so a same-edge expiry re-sets EXP.
        if (IOBUS_WR && sel_stat && IOBUS_OUT[0]) begin
            exp_d = 1'b0;
        end

        if (IOBUS_WR && sel_load) begin
            load_d  = IOBUS_OUT;
            count_d = IOBUS_OUT;
            presc_d = 16'd0;
        end else if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                exp_d  = 1'b1;
                intr_d = ctrl_q[2] && !intr_q;
                if (ctrl_q[1]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
        end

        // A CTRL write overrides the one-shot auto-disable above.
        if (IOBUS_WR && sel_ctrl) begin
            ctrl_d = IOBUS_OUT[2:0];
            if (!IOBUS_OUT[0]) begin
                presc_d = 16'd0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl_q  <= 3'd0;
            load_q  <= 32'd0;
            count_q <= 32'd0;
            exp_q   <= 1'b0;
            presc_q <= 16'd0;
            intr_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            presc_q <= presc_d;
            intr_q  <= intr_d;
        end
    end

    always_comb begin
        IOBUS_IN = 32'd0;
        if (sel_ctrl) begin
            IOBUS_IN = {29'd0, ctrl_q};
        end else if (sel_load) begin
            IOBUS_IN = load_q;
        end else if (sel_count) begin
            IOBUS_IN = count_q;
        end else if (sel_stat) begin
            IOBUS_IN = {31'd0, exp_q};
        end
    end

    assign INTR = intr_q;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// tb/tb_otter_iobus_timer.sv - self-checking bench for otter_iobus_timer
module tb_otter_iobus_timer;

    localparam int          P = 4;
    localparam logic [31:0] B = 32'h1101_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IOBUS_ADDR = 32'd0;
    logic [31:0] IOBUS_OUT = 32'd0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        INTR;

    otter_iobus_timer #(.BASE_ADDR(B), .PRESCALE(P)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .INTR       (INTR)
    );

    always #10 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    bit last_intr;

    // Reference state: timer settings plus how far into the current tick period we are.
    bit          m_en, m_auto, m_ie, m_exp, m_intr;
    logic [31:0] m_load, m_count;
    int          m_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic m_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_intr = 0;
        m_load = 0; m_count = 0; m_phase = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == B)        return {29'd0, m_ie, m_auto, m_en};
        if (a == B + 4)    return m_load;
        if (a == B + 8)    return m_count;
        if (a == B + 12)   return {31'd0, m_exp};
        return 32'd0;
    endfunction

    task automatic model_step(input bit wr, input logic [31:0] a, input logic [31:0] d);
        bit tick, fire, ld, prev;
        tick = m_en && (m_phase == P - 1);
        ld   = wr && (a == B + 4);
        fire = tick && (m_count == 0) && !ld;
        prev = m_intr;
        m_intr = fire && m_ie && !prev;
        if (wr && a == B + 12 && d[0]) m_exp = 0;
        if (ld) begin
            m_load = d; m_count = d; m_phase = 0;
        end else if (tick) begin
            m_phase = 0;
            if (fire) begin
                m_exp = 1;
                if (m_auto) m_count = m_load;
                else        m_en = 0;
            end else begin
                m_count = m_count - 1;
            end
        end else if (m_en) begin
            m_phase = m_phase + 1;
        end
        if (wr && a == B) begin
            m_en = d[0]; m_auto = d[1]; m_ie = d[2];
        end
        if (!m_en) m_phase = 0;
    endtask

    task automatic cycle(input bit wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d;
        #1 check("intr", INTR, m_intr);
        @(posedge CLK);
        model_step(wr, a, d);
        #1;
        IOBUS_WR = 1'b0;
        last_intr = INTR;
    endtask

    task automatic idle();
        cycle(0, B + 8, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        IOBUS_WR = 1'b0; IOBUS_ADDR = a;
        #1 check(tag, IOBUS_IN, exp);
    endtask

    task automatic rd_model(input string tag);
        for (int i = 0; i < 4; i++) rd(tag, B + 32'(4 * i), m_read(B + 32'(4 * i)));
    endtask

    initial begin
        int first, pulses, found, prev_t;
        int times[$];
        logic [31:0] a, d;

        m_reset();
        #3;
        for (int i = 0; i < 4; i++) rd("reset_reg", B + 32'(4 * i), 32'd0);
        check("reset_intr", INTR, 1'b0);
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;

        // One-shot with interrupt enabled.
        cycle(1, B + 4, 3);
        cycle(1, B, 5);
        first = -1; pulses = 0;
        for (int k = 1; k <= 116; k++) begin
            idle();
            if (last_intr) begin pulses++; if (first < 0) first = k; end
        end
        check("oneshot_first", first, 16);
        check("oneshot_pulses", pulses, 1);
        rd("oneshot_ctrl", B, 32'h4);
        rd("oneshot_count", B + 8, 32'd0);
        rd("oneshot_exp", B + 12, 32'd1);

        // Auto-reload, with a STATUS clear between pulses.
        cycle(1, B + 12, 1);
        cycle(1, B + 4, 2);
        cycle(1, B, 7);
        for (int k = 1; k <= 60; k++) begin
            if (k == 30) cycle(1, B + 12, 1);
            else idle();
            if (last_intr) times.push_back(k);
            if (k > 30 && k < 36) rd("auto_exp_cleared", B + 12, 32'd0);
        end
        rd("auto_exp_reset", B + 12, 32'd1);
        check("auto_pulses", times.size(), 5);
        prev_t = 0;
        foreach (times[i]) begin
            check("auto_period", times[i] - prev_t, 12);
            prev_t = times[i];
        end

        // Collision: STATUS clear on the expiry edge, then LOAD on a tick edge.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_en && m_phase == P - 1 && m_count == 0) found = 1;
            else idle();
        end
        check("coll_wait_expiry", found, 1);
        cycle(1, B + 12, 1);
        rd("coll_exp_set_wins", B + 12, 32'd1);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (m_en && m_phase == P - 1) found = 1;
            else idle();
        end
        check("coll_wait_tick", found, 1);
        cycle(1, B + 4, 9);
        rd("coll_load_wins", B + 8, 32'd9);
        cycle(1, B, 0);

        // Pause and resume.
        cycle(1, B + 4, 8);
        cycle(1, B, 1);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (m_count == 5 && m_phase != P - 1) found = 1;
            else idle();
        end
        check("pause_wait", found, 1);
        cycle(1, B, 0);
        repeat (50) idle();
        rd("pause_held", B + 8, 32'd5);
        cycle(1, B, 1);
        repeat (P - 1) idle();
        rd("resume_early", B + 8, 32'd5);
        idle();
        rd("resume_tick", B + 8, 32'd4);
        cycle(1, B, 0);

        // Decode and IE=0 expiry.
        rd("dec_hole", B + 16, 32'd0);
        rd("dec_outside", 32'h1100_0000, 32'd0);
        cycle(1, B + 8, 32'hFFFF);
        rd("dec_count_ro", B + 8, 32'd4);
        cycle(1, B + 12, 1);
        cycle(1, B + 4, 0);
        cycle(1, B, 1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            idle();
            if (last_intr) pulses++;
        end
        check("noie_pulses", pulses, 0);
        rd("noie_exp", B + 12, 32'd1);
        rd("noie_ctrl", B, 32'd0);

        // Randomized bus traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            d = $urandom;
            case ($urandom_range(0, 9))
                0, 1: cycle(1, B, d);
                2:    cycle(1, B + 4, 32'($urandom_range(0, 6)));
                3:    cycle(1, B + 12, d);
                4:    cycle(1, B + 8, d);
                5: begin
                    a = B + 32'($urandom_range(4, 8) * 4);
                    cycle(1, a, d);
                end
                default: idle();
            endcase
            rd_model("rand_reg");
        end

        // Reset while an interrupt pulse is on the wire.
        cycle(1, B + 4, 1);
        cycle(1, B, 7);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            idle();
            if (last_intr) found = 1;
        end
        check("rst_wait_pulse", found, 1);
        RESET = 1'b1;
        #1 check("rst_intr_drop", INTR, 1'b0);
        for (int i = 0; i < 4; i++) rd("rst_reg", B + 32'(4 * i), 32'd0);
        m_reset();
        @(negedge CLK);
        RESET = 1'b0;
        idle();
        rd_model("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/otter_iobus_timer.md
Name: otter_iobus_timer

Overview:
- Memory-mapped interval timer that responds to the OTTER MCU I/O bus (IOBUS_ADDR/IOBUS_OUT/IOBUS_WR in, IOBUS_IN out).
- Generates the interrupt pulse into the MCU INTR input. This is the peripheral-to-CPU direction, complementing the MCU's output-port writes.
- Instantiated beside the wrapper's port decode. Its IOBUS_IN contribution is ORed into the wrapper input mux, and its INTR is ORed with the button one-shot.

Parameters:
- BASE_ADDR, 32'h11010000, word-aligned base of the 4-register block.
- PRESCALE, 16, CLK cycles per count tick; legal range 1..65535.

Ports:
- CLK  in  1  system clock (divided s_clk domain).
- RESET  in  1  asynchronous, active-high reset.
- IOBUS_ADDR  in  32  bus address from MCU.
- IOBUS_OUT  in  32  bus write data from MCU.
- IOBUS_WR  in  1  write strobe, valid for one CLK cycle.
- IOBUS_IN  out  32  read data; 0 when address not in block.
- INTR  out  1  one-cycle interrupt pulse to MCU.

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0 CTRL (RW): bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable); other bits read 0.
  - +4 LOAD (RW, 32 bits).
  - +8 COUNT (RO; writes ignored).
  - +C STATUS: bit0 EXP flag, write-1-to-clear; writing 0 has no effect.
- Addresses in the block that match no register, and all addresses outside it, read 0. Decode is exact 32-bit compare.
- Reads: IOBUS_IN is combinational from IOBUS_ADDR and current register state, with zero latency, the same as the wrapper switch/button mux.
- Writes: take effect on the CLK edge where IOBUS_WR=1 and the address matches.
- Reset (async, RESET=1): CTRL=0, LOAD=0, COUNT=0, EXP=0, prescaler=0, INTR=0. IOBUS_IN therefore reads 0 at all offsets.
- Writing LOAD also sets COUNT<=IOBUS_OUT and prescaler<=0 on the same edge.
- Prescaler runs only while EN=1. It counts 0..PRESCALE-1, asserts tick when it equals PRESCALE-1, then wraps to 0. It is held at 0 while EN=0. With PRESCALE=1, tick occurs every cycle.
- On tick:
  - If COUNT!=0, COUNT<=COUNT-1.
  - If COUNT==0, expiry:
    - EXP<=1.
    - INTR<=1 for exactly the next cycle if IE=1.
    - AUTO=1: COUNT<=LOAD.
    - AUTO=0: COUNT stays 0 and EN<=0 (one-shot).
- Period: expiry every (LOAD+1)*PRESCALE cycles in auto mode. LOAD=0 with AUTO gives expiry on every tick.
- INTR is registered and never high two consecutive cycles. This matches the one-shot pulse width the MCU expects.
- Simultaneous events:
  - STATUS clear and expiry on the same edge: EXP=1 (set wins).
  - CTRL write and one-shot expiry on the same edge: the written CTRL value wins, including EN.
  - LOAD write and tick on the same edge: the LOAD write wins; no decrement, no expiry.
  - EN written 0 mid-count: COUNT freezes and the prescaler clears. Re-enable resumes from the frozen COUNT with a full PRESCALE delay to the first tick.
- RESET asserted mid-count: all state clears immediately. Any pending INTR pulse is dropped.

Test Plan:
- Reset: assert RESET mid-count with EN=1 -> IOBUS_IN=0 at all four offsets; INTR=0 immediately, no clock edge needed.
- One-shot (PRESCALE=4): write LOAD=3, then CTRL=0x5 -> INTR pulses exactly once, 16 cycles after the CTRL write edge. Then EXP=1, CTRL reads 0x4, COUNT=0, and no further pulses over 100 cycles.
- Auto-reload (PRESCALE=4): LOAD=2, CTRL=0x7 -> INTR pulses every 12 cycles for 5 periods. Write STATUS=1 between pulses -> EXP reads 0 until the next expiry.
- Collision: STATUS=1 written on the expiry edge -> EXP reads 1. LOAD=9 written on a tick edge -> COUNT reads 9 next cycle.
- Pause: disable at COUNT=5, wait 50 cycles -> COUNT=5 held. Re-enable -> COUNT=4 after exactly PRESCALE cycles.
- Decode: read BASE+0x10, read 0x11000000, and write COUNT=0xFFFF -> reads return 0 and COUNT is unchanged. IE=0 with expiry -> EXP=1 and INTR stays 0.
